key_reduction_iter: RTL and testbench

Parametrised, iterative successor to the fixed 512→16 key reducer. It accepts a KEY_W-bit key over a valid/ready handshake and folds it to OUT_W bits. Each fold stage is one clock cycle and applies a rotate, a halving fold, and a per-stage boolean operator chosen by a runtime mode. It sits between the key-load path and the round-key consumers of the crypto engine, and adds back-pressure and a selectable fold mode.

---
 rtl/key_red_pkg.sv | 32 +++
 rtl/key_red_fold_stage.sv | 69 ++++++
 rtl/key_reduction_iter.sv | 93 +++++++++
 tb/tb_key_reduction_iter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/key_red_pkg.sv
// Shared types and constants for the iterative key reducer.
// Optional KEY_RED_ZEROIZE_EN build clears key material after the output handshake.
package key_red_pkg;

    typedef enum logic [1:0] {
        MODE_XOR = 2'd0,
        MODE_MIX = 2'd1,
        MODE_RC  = 2'd2,
        MODE_RSV = 2'd3
    } fold_mode_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FOLD = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [31:0] RC [8] = '{
        32'h9E3779B9, 32'h7F4A7C15, 32'hF39CC060, 32'h5851F42D,
        32'hC6A4A793, 32'h2545F491, 32'h94D049BB, 32'hBF58476D
    };

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v)
                r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/key_red_fold_stage.sv
// One fold stage: rotate, halve and combine, selected by stage index.
// Each stage has its own constant width and rotate; stg picks one.
module key_red_fold_stage
    import key_red_pkg::*;
#(
    parameter int KEY_W = 512,
    parameter int ROT   = 7,
    parameter int NSTG  = 5,
    parameter int CNT_W = 3
) (
    input  logic [KEY_W-1:0] work,
    input  logic [CNT_W-1:0] stg,
    input  fold_mode_e       mode,
    output logic [KEY_W-1:0] nxt
);

    logic [KEY_W-1:0] cand [NSTG];

    for (genvar s = 0; s < NSTG; s++) begin : g_stg
        localparam int W   = KEY_W >> s;
        localparam int H   = W / 2;
        localparam int AMT = (ROT * (s + 1)) % W;

        logic [W-1:0] x;
        logic [W-1:0] r;
        logic [H-1:0] hi;
        logic [H-1:0] lo;
        logic [H-1:0] rc;
        logic [H-1:0] f;

        assign x = work[W-1:0];

        if (AMT == 0) begin : g_nrot
            assign r = x;
        end else begin : g_rot
            assign r = {x[W-AMT-1:0], x[W-1:W-AMT]};
        end

        assign hi = r[W-1:H];
        assign lo = r[H-1:0];

        for (genvar i = 0; i < H; i++) begin : g_rc
            assign rc[i] = RC[s % 8][i % 32];
        end

        // Per-stage operator; legacy mix alternates AND/OR after stage 0
        always_comb begin
            f = hi ^ lo;
            unique case (1'b1)
                (mode == MODE_MIX) && (s != 0):
                    f = (s % 2 == 1) ? (hi & lo) : (hi | lo);
                (mode == MODE_RC):
                    f = hi ^ lo ^ rc;
                default: ;
            endcase
        end

        assign cand[s] = {work[KEY_W-1:H], f};
    end

    // Select the stage addressed by the iteration counter
    always_comb begin
        nxt = work;
        for (int s = 0; s < NSTG; s++)
            if (stg == CNT_W'(s))
                nxt = cand[s];
    end

endmodule

// File: rtl/key_reduction_iter.sv
// Iterative KEY_W -> OUT_W key reducer with valid/ready on both sides.
// Define KEY_RED_ZEROIZE_EN to wipe red_key and work on output handshake.
module key_reduction_iter
    import key_red_pkg::*;
#(
    parameter int KEY_W = 512,
    parameter int OUT_W = 16,
    parameter int ROT   = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [KEY_W-1:0] key,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] red_key,
    output logic             busy
);

    localparam int NSTG  = clog2(KEY_W / OUT_W);
    localparam int CNT_W = (NSTG > 1) ? clog2(NSTG) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NSTG - 1);

    state_e           state;
    logic [KEY_W-1:0] work;
    logic [KEY_W-1:0] nxt;
    logic [CNT_W-1:0] cnt;
    fold_mode_e       mode_q;

    assign in_ready = ~busy;

    key_red_fold_stage #(
        .KEY_W(KEY_W),
        .ROT  (ROT),
        .NSTG (NSTG),
        .CNT_W(CNT_W)
    ) u_fold (
        .work(work),
        .stg (cnt),
        .mode(mode_q),
        .nxt (nxt)
    );

    // Control FSM: accept, fold one stage per cycle, hold result until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            work      <= '0;
            cnt       <= '0;
            mode_q    <= MODE_XOR;
            out_valid <= 1'b0;
            red_key   <= '0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        work   <= key;
                        mode_q <= fold_mode_e'(mode);
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= S_FOLD;
                    end
                end
                S_FOLD: begin
                    work <= nxt;
                    if (cnt == LAST) begin
                        red_key   <= nxt[OUT_W-1:0];
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
`ifdef KEY_RED_ZEROIZE_EN
                        red_key   <= '0;
                        work      <= '0;
`endif
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_key_reduction_iter.sv
// Self-checking bench for key_reduction_iter (ROT=7 and ROT=0 instances).
// Directed table vectors, corner sequences and model-checked random keys.
module tb_key_reduction_iter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [511:0] key = '0;
    logic [1:0]   mode = '0;
    logic         in_ready, out_valid, busy;
    logic         in_ready0, out_valid0, busy0;
    logic [15:0]  red_key, red_key0;

    int nvec = 0;
    int nerr = 0;

    logic [31:0] rc_tab [8] = '{
        32'h9E3779B9, 32'h7F4A7C15, 32'hF39CC060, 32'h5851F42D,
        32'hC6A4A793, 32'h2545F491, 32'h94D049BB, 32'hBF58476D
    };

    typedef struct {
        logic [511:0] k;
        logic [1:0]   m;
        logic [15:0]  e0;
        logic [15:0]  e7;
    } vec_t;

    vec_t tbl [12];

    always #5 clk = ~clk;

    key_reduction_iter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .key      (key),
        .mode     (mode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .red_key  (red_key),
        .busy     (busy)
    );

    key_reduction_iter #(.ROT(0)) dut0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready0),
        .key      (key),
        .mode     (mode),
        .out_valid(out_valid0),
        .out_ready(out_ready),
        .red_key  (red_key0),
        .busy     (busy0)
    );

    function automatic logic [15:0] ref_fold(logic [511:0] k, logic [1:0] m, int rot);
        logic [511:0] x, r, y;
        logic p, q, c;
        int w, h, a;
        x = k;
        w = 512;
        for (int s = 0; s < 5; s++) begin
            a = (rot * (s + 1)) % w;
            h = w / 2;
            r = '0;
            y = x;
            for (int i = 0; i < w; i++)
                r[(i + a) % w] = x[i];
            for (int i = 0; i < h; i++) begin
                p = r[i + h];
                q = r[i];
                c = rc_tab[s % 8][i % 32];
                case (m)
                    2'd1: y[i] = (s == 0) ? (p ^ q) :
                                 ((s % 2 == 1) ? (p & q) : (p | q));
                    2'd2: y[i] = p ^ q ^ c;
                    default: y[i] = p ^ q;
                endcase
            end
            x = y;
            w = h;
        end
        return x[15:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [511:0] k, input logic [1:0] m);
        key = k;
        mode = m;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
    endtask

    task automatic take();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [511:0] one, top, k;
        logic [15:0]  hold, e0, e7;
        logic         seen;
        int           lat, stall;

        one = 512'd1;
        top = {1'b1, 511'd0};
        tbl[0]  = '{'1,   2'd0, 16'h0000, 16'h0000};
        tbl[1]  = '{'1,   2'd1, 16'h0000, 16'h0000};
        tbl[2]  = '{'1,   2'd2, 16'h0BEF, 16'hC476};
        tbl[3]  = '{'0,   2'd2, 16'h0BEF, 16'hC476};
        tbl[4]  = '{one,  2'd0, 16'h0001, 16'h0200};
        tbl[5]  = '{one,  2'd1, 16'h0000, 16'h0000};
        tbl[6]  = '{one,  2'd2, 16'h0BEE, 16'hC676};
        tbl[7]  = '{top,  2'd0, 16'h8000, 16'h0100};
        tbl[8]  = '{top,  2'd3, 16'h8000, 16'h0100};
        tbl[9]  = '{one,  2'd3, 16'h0001, 16'h0200};
        tbl[10] = '{'0,   2'd0, 16'h0000, 16'h0000};
        tbl[11] = '{top,  2'd1, 16'h0000, 16'h0000};

        // reset and idle
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_red_key", 64'(red_key), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);

        // out_ready with nothing pending is ignored
        take();
        chk("idle_out_ready", 64'({out_valid, in_ready, busy}), 64'b010);

        // directed table
        foreach (tbl[i]) begin
            send(tbl[i].k, tbl[i].m);
            wait_out(lat);
            chk($sformatf("tbl%0d_lat", i), 64'(lat), 64'd5);
            chk($sformatf("tbl%0d_rot7", i), 64'(red_key), 64'(tbl[i].e7));
            chk($sformatf("tbl%0d_rot0", i), 64'(red_key0), 64'(tbl[i].e0));
            take();
            chk($sformatf("tbl%0d_drop", i), 64'(out_valid), 64'd0);
        end

        // back-pressure with a second key waiting
        send(one, 2'd0);
        wait_out(lat);
        chk("bp_lat", 64'(lat), 64'd5);
        hold = red_key;
        key = top;
        mode = 2'd0;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("bp_hold%0d", i),
                64'({out_valid, in_ready, red_key}), 64'({1'b1, 1'b0, hold}));
        end
        take();
        chk("bp_release", 64'({out_valid, in_ready}), 64'b01);
        step();
        in_valid = 1'b0;
        chk("bp_accept", 64'(busy), 64'd1);
        wait_out(lat);
        chk("bp2_lat", 64'(lat), 64'd5);
        chk("bp2_rot7", 64'(red_key), 64'h0100);
        chk("bp2_rot0", 64'(red_key0), 64'h8000);
        take();

        // reset after two fold cycles
        send('1, 2'd2);
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_state",
            64'({out_valid, busy, in_ready, red_key}), 64'({1'b0, 1'b0, 1'b1, 16'h0}));
        chk("mid_rst_red0", 64'(red_key0), 64'd0);
        step();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            seen = seen | out_valid | out_valid0;
        end
        chk("mid_rst_no_out", 64'(seen), 64'd0);
        chk("mid_rst_idle", 64'({in_ready, red_key}), 64'({1'b1, 16'h0}));

        // random keys against the model, random output stalls
        for (int n = 0; n < 24; n++) begin
            for (int j = 0; j < 16; j++)
                k[j*32 +: 32] = $urandom;
            mode = 2'($urandom_range(0, 3));
            e7 = ref_fold(k, mode, 7);
            e0 = ref_fold(k, mode, 0);
            send(k, mode);
            key = ~k;
            wait_out(lat);
            chk($sformatf("rnd%0d_lat", n), 64'(lat), 64'd5);
            chk($sformatf("rnd%0d_rot7", n), 64'(red_key), 64'(e7));
            chk($sformatf("rnd%0d_rot0", n), 64'(red_key0), 64'(e0));
            stall = $urandom_range(0, 3);
            for (int s = 0; s < stall; s++) begin
                step();
                chk($sformatf("rnd%0d_stall", n), 64'({out_valid, red_key}), 64'({1'b1, e7}));
            end
            take();
`ifdef KEY_RED_ZEROIZE_EN
            chk($sformatf("rnd%0d_zero", n), 64'({red_key, red_key0}), 64'd0);
`else
            chk($sformatf("rnd%0d_keep", n), 64'({red_key, red_key0}), 64'({e7, e0}));
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
